// File: rtl/toy_mem_arbiter.sv
// toy_mem_arbiter: round-robin arbiter and burst sequencer for a single-port,
// word-addressed toy memory shared by NUM_REQ requesters.
// Reads are issued as wrapping, critical-word-first bursts of BURST_LEN words.
// Optional feature macro: TOY_MEM_ARB_WR_EN enables the single-word write path.
// When it is undefined, every request is treated as a burst read.

module toy_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_vld,
  output logic [NUM_REQ-1:0]           req_rdy,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                         mem_en,
  output logic                         mem_wr_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic                         rsp_vld,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_last
);

  // A one-beat burst still needs a 1-bit counter to keep the widths legal.
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ADDR_WIDTH'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [ID_W-1:0]       r_rrPtr;
  logic [CNT_W-1:0]      r_beatCnt;
  logic [ID_W-1:0]       r_id;
  logic [ADDR_WIDTH-1:0] r_base;

  logic                  r_memEn;
  logic [ADDR_WIDTH-1:0] r_memAddr;

  logic                  r_rspVld;
  logic                  r_rspWr;
  logic [ID_W-1:0]       r_rspId;
  logic                  r_rspLast;

  logic                  w_anyVld;
  logic                  w_found;
  logic [ID_W-1:0]       w_winner;
  logic [ADDR_WIDTH-1:0] w_winAddr;
  logic                  w_accept;
  logic                  w_curWr;
  logic                  w_lastBeat;
  logic [CNT_W-1:0]      w_nextBeat;
  logic                  w_memWrEn;

`ifdef TOY_MEM_ARB_WR_EN
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_memWrEn;
  logic [DATA_WIDTH-1:0] r_memWrData;
  logic                  w_winWr;
  logic [DATA_WIDTH-1:0] w_winWdata;
`else
  // Write inputs are deliberately unused in the read-only build.
  logic w_unusedWrInputs;
  assign w_unusedWrInputs = ^{req_wr, req_wdata};
`endif

  // Burst address: upper bits of the base stay fixed, low bits wrap inside the aligned block.
  function automatic logic [ADDR_WIDTH-1:0] wrapAddr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [CNT_W-1:0]      beat);
    return (base & ~BLK_MASK) | ((base + ADDR_WIDTH'(beat)) & BLK_MASK);
  endfunction

  // Round-robin search: first valid requester at or above the pointer, wrapping around.
  always_comb begin
    w_anyVld = |req_vld;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_vld[ID_W'((int'(r_rrPtr) + k) % NUM_REQ)]) begin
        w_found  = 1'b1;
        w_winner = ID_W'((int'(r_rrPtr) + k) % NUM_REQ);
      end
    end
  end

  // Pick out the winning requester's address (and write payload when writes exist).
  always_comb begin
    w_winAddr  = '0;
`ifdef TOY_MEM_ARB_WR_EN
    w_winWr    = 1'b0;
    w_winWdata = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_winAddr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef TOY_MEM_ARB_WR_EN
        w_winWr    = req_wr[i];
        w_winWdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
    end
  end

  // Handshake and end-of-transaction decode shared by the FSM and the datapath.
  always_comb begin
    w_accept   = (r_state == IDLE) && w_anyVld;
`ifdef TOY_MEM_ARB_WR_EN
    w_curWr    = r_wr;
`else
    w_curWr    = 1'b0;
`endif
    w_lastBeat = (r_state == ISSUE) && (w_curWr || (r_beatCnt == LAST_BEAT));
    w_nextBeat = r_beatCnt + CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state: leave IDLE on any request, return after the final beat.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyVld)   w_nextState = ISSUE;
      ISSUE:   if (w_lastBeat) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: the one-hot grant is only offered while IDLE.
  always_comb begin
    req_rdy = '0;
    if ((r_state == IDLE) && w_anyVld) begin
      req_rdy[w_winner] = 1'b1;
    end
  end

  // Latch the accepted request, advance the pointer past the winner, and count beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr   <= '0;
      r_beatCnt <= '0;
      r_id      <= '0;
      r_base    <= '0;
`ifdef TOY_MEM_ARB_WR_EN
      r_wr      <= 1'b0;
      r_wdata   <= '0;
`endif
    end else if (w_accept) begin
      r_id      <= w_winner;
      r_base    <= w_winAddr;
      r_beatCnt <= '0;
      r_rrPtr   <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);
`ifdef TOY_MEM_ARB_WR_EN
      r_wr      <= w_winWr;
      r_wdata   <= w_winWdata;
`endif
    end else if ((r_state == ISSUE) && !w_lastBeat) begin
      r_beatCnt <= w_nextBeat;
    end
  end

  // Registered memory pins: loaded one cycle ahead so each ISSUE cycle drives its own beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memEn   <= 1'b0;
      r_memAddr <= '0;
    end else begin
      r_memEn <= (w_nextState == ISSUE);
      if (w_accept) begin
        r_memAddr <= w_winAddr;
      end else if ((r_state == ISSUE) && !w_lastBeat) begin
        r_memAddr <= wrapAddr(r_base, w_nextBeat);
      end else begin
        r_memAddr <= '0;
      end
    end
  end

`ifdef TOY_MEM_ARB_WR_EN
  // Write pins: a write is always a single beat, so they are only loaded at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memWrEn   <= 1'b0;
      r_memWrData <= '0;
    end else begin
      r_memWrEn   <= w_accept && w_winWr;
      r_memWrData <= (w_accept && w_winWr) ? w_winWdata : '0;
    end
  end

  assign w_memWrEn   = r_memWrEn;
  assign mem_wr_data = r_memWrData;
`else
  assign w_memWrEn   = 1'b0;
  assign mem_wr_data = '0;
`endif

  // Response pipeline: delay issue/write/id/last by one cycle to line up with read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspVld  <= 1'b0;
      r_rspWr   <= 1'b0;
      r_rspId   <= '0;
      r_rspLast <= 1'b0;
    end else begin
      r_rspVld  <= r_memEn;
      r_rspWr   <= w_memWrEn;
      r_rspId   <= r_memEn ? r_id : '0;
      r_rspLast <= w_lastBeat;
    end
  end

  assign mem_en    = r_memEn;
  assign mem_wr_en = w_memWrEn;
  assign mem_addr  = r_memAddr;
  assign rsp_vld   = r_rspVld;
  assign rsp_id    = r_rspId;
  assign rsp_last  = r_rspLast;
  assign rsp_data  = (r_rspVld && !r_rspWr) ? mem_rd_data : '0;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// tb_toy_mem_arbiter: directed self-checking bench for toy_mem_arbiter
// (NUM_REQ=4, 32-bit address/data, BURST_LEN=4) with a behavioural toy memory.
// Honours TOY_MEM_ARB_WR_EN to pick the write or read-only write scenario.

module tb_toy_mem_arbiter;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_vld;
  logic [3:0]    req_rdy;
  logic [3:0]    req_wr;
  logic [127:0]  req_addr;
  logic [127:0]  req_wdata;
  logic          mem_en;
  logic          mem_wr_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;
  logic          rsp_vld;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          rsp_last;

  int checkCount;
  int failCount;

  logic [31:0] memWritten [logic [31:0]];

  toy_mem_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_last(rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten words read back as {addr[15:0], ~addr[15:0]}.
  function automatic logic [31:0] fillWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Toy memory: one-cycle read latency, writes land at the clock edge.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) memWritten[mem_addr] = mem_wr_data;
      else mem_rd_data <= memWritten.exists(mem_addr) ? memWritten[mem_addr] : fillWord(mem_addr);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int id, input logic [31:0] a, input logic wr, input logic [31:0] d);
    req_addr[id*32 +: 32]  = a;
    req_wdata[id*32 +: 32] = d;
    req_wr[id]             = wr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    #3;
    checkCount++;
    if ({req_rdy, mem_en, mem_wr_en, rsp_vld, rsp_last} !== 8'h00) begin
      $display("[TB] FAIL reset_ctrl: got %b expected 00000000", {req_rdy, mem_en, mem_wr_en, rsp_vld, rsp_last});
      failCount++;
    end
    checkCount++;
    if ({mem_addr, mem_wr_data, rsp_data, rsp_id} !== 98'h0) begin
      $display("[TB] FAIL reset_data: addr %h wdata %h rdata %h id %0d expected all 0", mem_addr, mem_wr_data, rsp_data, rsp_id);
      failCount++;
    end
    stepCycle();
    @(negedge clk) rst_n = 1'b1;
    stepCycle();
    stepCycle();
    checkCount++;
    if ({req_rdy, mem_en, rsp_vld, mem_addr} !== 38'h0) begin
      $display("[TB] FAIL idle_no_req: rdy %b en %b rv %b addr %h expected 0", req_rdy, mem_en, rsp_vld, mem_addr);
      failCount++;
    end
  endtask

  task automatic test_contention();
    int order[5] = '{0, 1, 2, 3, 0};
    int waitCycles;
    for (int i = 0; i < 4; i++) setReq(i, 32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0);
    req_vld = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      waitCycles = (g == 0) ? 0 : 1;
      while (req_rdy === 4'b0000 && waitCycles < 20) begin
        stepCycle();
        waitCycles++;
      end
      checkCount++;
      if (req_rdy !== (4'b0001 << order[g])) begin
        $display("[TB] FAIL grant_%0d: req_rdy %b expected %b", g, req_rdy, 4'b0001 << order[g]);
        failCount++;
      end
      checkCount++;
      if (mem_en !== 1'b0) begin
        $display("[TB] FAIL grant_idle_%0d: mem_en %b expected 0", g, mem_en);
        failCount++;
      end
      if (g > 0) begin
        checkCount++;
        if (waitCycles != 5) begin
          $display("[TB] FAIL grant_gap_%0d: %0d cycles expected 5", g, waitCycles);
          failCount++;
        end
      end
      stepCycle();
    end
    req_vld = '0;
    for (int c = 0; c < 6; c++) stepCycle();
  endtask

  task automatic test_single_read();
    logic [31:0] expAddr[4] = '{32'h102, 32'h103, 32'h100, 32'h101};
    logic [31:0] expData[4] = '{32'h0102FEFD, 32'h0103FEFC, 32'h0100FEFF, 32'h0101FEFE};
    logic        eEn, eRv, eLast;
    logic [31:0] eAddr, eData;
    setReq(0, 32'h102, 1'b0, 32'h0);
    req_vld = 4'b0001;
    #1;
    checkCount++;
    if (req_rdy !== 4'b0001) begin
      $display("[TB] FAIL read_rdy: req_rdy %b expected 0001", req_rdy);
      failCount++;
    end
    stepCycle();
    req_vld = '0;
    for (int c = 1; c <= 6; c++) begin
      eEn   = (c <= 4);
      eAddr = eEn ? expAddr[c-1] : 32'h0;
      eRv   = (c >= 2) && (c <= 5);
      eData = eRv ? expData[c-2] : 32'h0;
      eLast = (c == 5);
      checkCount++;
      if (mem_en !== eEn || mem_addr !== eAddr || mem_wr_en !== 1'b0) begin
        $display("[TB] FAIL read_issue_T+%0d: en %b addr %h wr %b expected en %b addr %h wr 0", c, mem_en, mem_addr, mem_wr_en, eEn, eAddr);
        failCount++;
      end
      checkCount++;
      if (rsp_vld !== eRv || rsp_data !== eData || rsp_last !== eLast || rsp_id !== 2'd0) begin
        $display("[TB] FAIL read_rsp_T+%0d: vld %b data %h last %b id %0d expected vld %b data %h last %b id 0", c, rsp_vld, rsp_data, rsp_last, rsp_id, eRv, eData, eLast);
        failCount++;
      end
      stepCycle();
    end
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    setReq(1, 32'h200, 1'b0, 32'h0);
    req_vld = 4'b0010;
    stepCycle();
    req_vld = '0;
    stepCycle();
    checkCount++;
    if (mem_en !== 1'b1 || rsp_vld !== 1'b1) begin
      $display("[TB] FAIL midburst_active: en %b rv %b expected 1 1", mem_en, rsp_vld);
      failCount++;
    end
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if ({req_rdy, mem_en, mem_wr_en, rsp_vld, rsp_last, mem_addr, rsp_data, rsp_id} !== 74'h0) begin
      $display("[TB] FAIL async_reset: en %b addr %h rv %b last %b data %h expected all 0", mem_en, mem_addr, rsp_vld, rsp_last, rsp_data);
      failCount++;
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      if (rsp_vld !== 1'b0 || mem_en !== 1'b0) seen++;
    end
    checkCount++;
    if (seen != 0) begin
      $display("[TB] FAIL after_reset_quiet: %0d active cycles expected 0", seen);
      failCount++;
    end
    for (int i = 0; i < 4; i++) setReq(i, 32'h300 + 32'(i), 1'b0, 32'h0);
    req_vld = 4'b1111;
    #1;
    checkCount++;
    if (req_rdy !== 4'b0001) begin
      $display("[TB] FAIL post_reset_grant: req_rdy %b expected 0001", req_rdy);
      failCount++;
    end
    stepCycle();
    req_vld = '0;
    for (int c = 0; c < 6; c++) stepCycle();
  endtask

`ifdef TOY_MEM_ARB_WR_EN
  task automatic test_write_then_read();
    setReq(2, 32'h40, 1'b1, 32'hDEADBEEF);
    req_vld = 4'b0100;
    #1;
    checkCount++;
    if (req_rdy !== 4'b0100) begin
      $display("[TB] FAIL write_rdy: req_rdy %b expected 0100", req_rdy);
      failCount++;
    end
    stepCycle();
    req_vld = '0; req_wr = '0;
    checkCount++;
    if (mem_en !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 32'h40 || mem_wr_data !== 32'hDEADBEEF) begin
      $display("[TB] FAIL write_issue: en %b wr %b addr %h data %h expected 1 1 00000040 deadbeef", mem_en, mem_wr_en, mem_addr, mem_wr_data);
      failCount++;
    end
    stepCycle();
    checkCount++;
    if (rsp_vld !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h0 || rsp_last !== 1'b1 || mem_en !== 1'b0) begin
      $display("[TB] FAIL write_ack: vld %b id %0d data %h last %b en %b expected 1 2 0 1 0", rsp_vld, rsp_id, rsp_data, rsp_last, mem_en);
      failCount++;
    end
    setReq(1, 32'h40, 1'b0, 32'h0);
    req_vld = 4'b0010;
    #1;
    checkCount++;
    if (req_rdy !== 4'b0010) begin
      $display("[TB] FAIL read_after_write_rdy: req_rdy %b expected 0010", req_rdy);
      failCount++;
    end
    stepCycle();
    req_vld = '0;
    stepCycle();
    checkCount++;
    if (rsp_vld !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'hDEADBEEF || rsp_last !== 1'b0) begin
      $display("[TB] FAIL read_after_write_data: vld %b id %0d data %h last %b expected 1 1 deadbeef 0", rsp_vld, rsp_id, rsp_data, rsp_last);
      failCount++;
    end
    for (int c = 0; c < 5; c++) stepCycle();
  endtask
`else
  task automatic test_write_disabled();
    int enCycles;
    int wrCycles;
    int lastCycle;
    setReq(2, 32'h40, 1'b1, 32'hDEADBEEF);
    req_vld = 4'b0100;
    stepCycle();
    req_vld = '0; req_wr = '0;
    enCycles = 0; wrCycles = 0; lastCycle = 0;
    for (int c = 1; c <= 6; c++) begin
      if (mem_en === 1'b1) enCycles++;
      if (mem_wr_en !== 1'b0 || mem_wr_data !== 32'h0) wrCycles++;
      if (rsp_last === 1'b1) lastCycle = c;
      if (c == 2) begin
        checkCount++;
        if (rsp_vld !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h0040FFBF) begin
          $display("[TB] FAIL nowr_first_beat: vld %b id %0d data %h expected 1 2 0040ffbf", rsp_vld, rsp_id, rsp_data);
          failCount++;
        end
      end
      stepCycle();
    end
    checkCount++;
    if (enCycles != 4) begin
      $display("[TB] FAIL nowr_beats: %0d issue cycles expected 4", enCycles);
      failCount++;
    end
    checkCount++;
    if (wrCycles != 0) begin
      $display("[TB] FAIL nowr_wr_en: %0d write cycles expected 0", wrCycles);
      failCount++;
    end
    checkCount++;
    if (lastCycle != 5) begin
      $display("[TB] FAIL nowr_last: rsp_last at T+%0d expected T+5", lastCycle);
      failCount++;
    end
  endtask
`endif

  task automatic test_top_wrap();
    logic [31:0] expAddr[4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE};
    setReq(3, 32'hFFFFFFFF, 1'b0, 32'h0);
    req_vld = 4'b1000;
    stepCycle();
    req_vld = '0;
    for (int c = 1; c <= 4; c++) begin
      checkCount++;
      if (mem_en !== 1'b1 || mem_addr !== expAddr[c-1]) begin
        $display("[TB] FAIL wrap_addr_%0d: en %b addr %h expected 1 %h", c, mem_en, mem_addr, expAddr[c-1]);
        failCount++;
      end
      if (c == 2) begin
        checkCount++;
        if (rsp_vld !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'hFFFF0000) begin
          $display("[TB] FAIL wrap_rsp: vld %b id %0d data %h expected 1 3 ffff0000", rsp_vld, rsp_id, rsp_data);
          failCount++;
        end
      end
      stepCycle();
    end
    for (int c = 0; c < 3; c++) stepCycle();
  endtask

  // Safety net so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    failCount  = 0;
    mem_rd_data = '0;
    test_reset();
    test_contention();
    test_single_read();
    test_reset_mid_burst();
`ifdef TOY_MEM_ARB_WR_EN
    test_write_then_read();
`else
    test_write_disabled();
`endif
    test_top_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
